// File: rtl/elevator_pkg.sv
// Shared elevator definitions: door state encoding and door timing defaults.
// The floor/motion controller imports this to decode door status.
package elevator_pkg;

    typedef enum logic [2:0] {
        DS_CLOSED  = 3'd0,
        DS_OPENING = 3'd1,
        DS_DWELL   = 3'd2,
        DS_CLOSING = 3'd3,
        DS_FAULT   = 3'd4
    } door_state_e;

    // Default cycle budget for one door stroke (open or close)
    localparam int DOOR_MOTION_LIMIT = 16;

endpackage

// File: rtl/door_motion_wdt.sv
// Door travel watchdog: saturating cycle counter with synchronous clear.
// 'expired' flags the cycle whose edge brings the count up to MOTION_LIMIT,
// so the FSM leaves a stroke on exactly the MOTION_LIMIT-th edge after entry.
// It depends only on the registered count and 'en' (never on 'clr'), which
// keeps it free of any combinational path back from the FSM next state.
module door_motion_wdt
    import elevator_pkg::*;
#(
    parameter int MOTION_LIMIT = DOOR_MOTION_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(MOTION_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(MOTION_LIMIT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(MOTION_LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign expired = en && (count_q == LIMIT_M1);

endmodule

// File: rtl/door_ctrl.sv
// Elevator car door sequencer. Starts the shared dwell timer with KT, closes
// on its expiry T, supervises door travel and reports when the car may move.
// All outputs are registered from the next state so they track the state.
module door_ctrl
    import elevator_pkg::*;
#(
    parameter int MOTION_LIMIT = DOOR_MOTION_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic car_stopped,
    input  logic stop_req,
    input  logic open_btn,
    input  logic close_btn,
    input  logic obstruct,
    input  logic lim_open,
    input  logic lim_closed,
    input  logic T,
    input  logic fault_clr,
    output logic KT,
    output logic motor_open,
    output logic motor_close,
    output logic door_secure,
    output logic fault
);

    door_state_e state_q, state_d;
    logic kt_q, kt_d;
    logic motor_open_q, motor_open_d;
    logic motor_close_q, motor_close_d;
    logic door_secure_q, door_secure_d;
    logic fault_q, fault_d;

    logic restart;
    logic wdt_clr;
    logic wdt_en;
    logic wdt_expired;

    door_motion_wdt #(
        .MOTION_LIMIT (MOTION_LIMIT)
    ) u_wdt (
        .clk     (clk),
        .reset   (reset),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    // Next state, watchdog control and registered output decode
    always_comb begin
        state_d = state_q;
        restart = 1'b0;

        // Both limit switches at once means a broken sensor or linkage
        if ((state_q != DS_FAULT) && lim_open && lim_closed) begin
            state_d = DS_FAULT;
        end else begin
            case (state_q)
                DS_CLOSED: begin
                    if (stop_req || (open_btn && car_stopped)) state_d = DS_OPENING;
                end
                DS_OPENING: begin
                    if (lim_open)         state_d = DS_DWELL;
                    else if (wdt_expired) state_d = DS_FAULT;
                end
                DS_DWELL: begin
                    // A T seen while KT is high predates the restart: stale
                    if (open_btn || obstruct) restart = 1'b1;
                    else if (close_btn)       state_d = DS_CLOSING;
                    else if (T && !kt_q)      state_d = DS_CLOSING;
                end
                DS_CLOSING: begin
                    if (obstruct || open_btn) state_d = DS_OPENING;
                    else if (lim_closed)      state_d = DS_CLOSED;
                    else if (wdt_expired)     state_d = DS_FAULT;
                end
                DS_FAULT: begin
                    if (fault_clr) state_d = DS_CLOSING;
                end
                default: state_d = DS_FAULT;
            endcase
        end

        // Every stroke entry, including a reopen, starts a fresh budget
        wdt_clr = (state_d != state_q) &&
                  ((state_d == DS_OPENING) || (state_d == DS_CLOSING));
        wdt_en  = (state_q == DS_OPENING) || (state_q == DS_CLOSING);

        kt_d          = (state_d == DS_DWELL) && ((state_q != DS_DWELL) || restart);
        motor_open_d  = (state_d == DS_OPENING);
        motor_close_d = (state_d == DS_CLOSING);
        door_secure_d = (state_d == DS_CLOSED) && lim_closed;
        fault_d       = (state_d == DS_FAULT);
    end

    // State and output registers; reset parks in CLOSING with outputs low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= DS_CLOSING;
            kt_q          <= 1'b0;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            door_secure_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            kt_q          <= kt_d;
            motor_open_q  <= motor_open_d;
            motor_close_q <= motor_close_d;
            door_secure_q <= door_secure_d;
            fault_q       <= fault_d;
        end
    end

    assign KT          = kt_q;
    assign motor_open  = motor_open_q;
    assign motor_close = motor_close_q;
    assign door_secure = door_secure_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_door_ctrl.sv
// Directed bench for door_ctrl with MOTION_LIMIT = 8. Each step pushes the
// expected output vector {KT, motor_open, motor_close, door_secure, fault}
// to a scoreboard; it is popped and checked 1 time unit after the edge.
module tb_door_ctrl;

    logic clk;
    logic reset;
    logic car_stopped, stop_req, open_btn, close_btn, obstruct;
    logic lim_open, lim_closed, T, fault_clr;
    logic KT, motor_open, motor_close, door_secure, fault;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_KT    = 5'b10000;
    localparam logic [4:0] O_OPEN  = 5'b01000;
    localparam logic [4:0] O_CLOSE = 5'b00100;
    localparam logic [4:0] O_SEC   = 5'b00010;
    localparam logic [4:0] O_FLT   = 5'b00001;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    door_ctrl #(.MOTION_LIMIT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .car_stopped (car_stopped),
        .stop_req    (stop_req),
        .open_btn    (open_btn),
        .close_btn   (close_btn),
        .obstruct    (obstruct),
        .lim_open    (lim_open),
        .lim_closed  (lim_closed),
        .T           (T),
        .fault_clr   (fault_clr),
        .KT          (KT),
        .motor_open  (motor_open),
        .motor_close (motor_close),
        .door_secure (door_secure),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [4:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic cmp();
        exp_t       x;
        logic [4:0] obs;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = {KT, motor_open, motor_close, door_secure, fault};
            n_tests++;
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic step(input string tag, input logic [4:0] e);
        push(tag, e);
        @(posedge clk);
        #1;
        cmp();
    endtask

    initial begin
        reset = 1'b1;
        car_stopped = 1'b1; stop_req = 1'b0; open_btn = 1'b0; close_btn = 1'b0;
        obstruct = 1'b0; lim_open = 1'b0; lim_closed = 1'b0; T = 1'b0;
        fault_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        push("reset_outputs", O_IDLE);
        cmp();

        // Door position unknown: first edge drives it closed
        reset = 1'b0;
        step("rel_closing", O_CLOSE);
        lim_closed = 1'b1;
        step("closed_secure", O_SEC);

        // 1. Normal cycle
        stop_req = 1'b1;
        step("t1_open", O_OPEN);
        stop_req = 1'b0; lim_closed = 1'b0;
        for (int i = 0; i < 3; i++) step("t1_opening", O_OPEN);
        lim_open = 1'b1;
        step("t1_kt", O_KT);
        for (int i = 0; i < 20; i++) step("t1_dwell", O_IDLE);
        T = 1'b1;
        step("t1_close", O_CLOSE);
        T = 1'b0; lim_open = 1'b0;
        step("t1_closing", O_CLOSE);
        lim_closed = 1'b1;
        step("t1_secure", O_SEC);

        // 2. Dwell extension and stale T
        stop_req = 1'b1; lim_closed = 1'b0;
        step("t2_open", O_OPEN);
        stop_req = 1'b0; lim_open = 1'b1;
        step("t2_kt", O_KT);
        step("t2_dwell", O_IDLE);
        obstruct = 1'b1;
        for (int i = 0; i < 3; i++) step("t2_restart", O_KT);
        obstruct = 1'b0; T = 1'b1;
        step("t2_stale_t", O_IDLE);
        step("t2_close", O_CLOSE);
        T = 1'b0; lim_open = 1'b0;

        // 3. Reopen beats lim_closed; watchdog restarts on reopen
        obstruct = 1'b1; lim_closed = 1'b1;
        step("t3_reopen", O_OPEN);
        obstruct = 1'b0; lim_closed = 1'b0;
        for (int i = 0; i < 7; i++) step("t3_wdt_run", O_OPEN);
        step("t3_wdt_fault", O_FLT);
        fault_clr = 1'b1;
        step("t3_clr", O_CLOSE);
        fault_clr = 1'b0; lim_closed = 1'b1;
        step("t3_closed", O_SEC);

        // 4. Watchdog fault from a stop request
        stop_req = 1'b1; lim_closed = 1'b0;
        step("t4_open", O_OPEN);
        stop_req = 1'b0;
        for (int i = 0; i < 7; i++) step("t4_wdt_run", O_OPEN);
        step("t4_wdt_fault", O_FLT);
        open_btn = 1'b1; T = 1'b1;
        step("t4_fault_hold", O_FLT);
        open_btn = 1'b0; T = 1'b0; fault_clr = 1'b1;
        step("t4_clr", O_CLOSE);
        fault_clr = 1'b0; lim_closed = 1'b1;
        step("t4_closed", O_SEC);

        // 5. Button gating and limit-switch conflict
        car_stopped = 1'b0; open_btn = 1'b1;
        step("t5_gate", O_SEC);
        step("t5_gate_hold", O_SEC);
        open_btn = 1'b0; car_stopped = 1'b1; lim_open = 1'b1;
        step("t5_conflict", O_FLT);
        lim_open = 1'b0; fault_clr = 1'b1;
        step("t5_clr", O_CLOSE);
        fault_clr = 1'b0;
        step("t5_closed", O_SEC);

        // 6. Async reset mid-OPENING and during a KT pulse
        open_btn = 1'b1; lim_closed = 1'b0;
        step("t6_open_btn", O_OPEN);
        open_btn = 1'b0;
        step("t6_opening", O_OPEN);
        #2 reset = 1'b1;
        #1;
        push("t6_async_open", O_IDLE);
        cmp();
        reset = 1'b0;
        step("t6_rel_closing", O_CLOSE);
        lim_closed = 1'b1;
        step("t6_closed", O_SEC);
        stop_req = 1'b1; lim_closed = 1'b0;
        step("t6_open2", O_OPEN);
        stop_req = 1'b0; lim_open = 1'b1;
        step("t6_kt", O_KT);
        #2 reset = 1'b1;
        #1;
        push("t6_async_kt", O_IDLE);
        cmp();
        lim_open = 1'b0; reset = 1'b0;
        step("t6_rel2_closing", O_CLOSE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
